mem_bus_arbiter: RTL and testbench

- Shares the single external memory bus (addr, cs, wr_rd, data_bus_write, data_bus_read) between two requesters: port 0 is the CPU memory stage, port 1 is the program-load/DMA engine.
- Round-robin arbitration with a req/gnt/done handshake.
- Multi-cycle bus transactions with a programmable minimum wait-state count, a ready input, and a timeout.
- Sits between the CPU's memory-stage bus outputs and the external memory/peripheral decoder.

---
 rtl/mem_bus_arbiter_pkg.sv | 34 +++
 rtl/mem_bus_arbiter_if.sv | 56 +++++
 rtl/mem_bus_arbiter_rr_arbiter2.sv | 29 ++
 rtl/mem_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-requester memory bus arbiter.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents:
//   ST_*      FSM state encoding used by mem_bus_arbiter
//   REQ_*     requester index constants (CPU memory stage, DMA/program loader)
//   bus_req_t packed view of one requester's transaction fields
package mem_bus_arbiter_pkg;

    // FSM encoding; fixed values because external debug logic decodes them.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Requester indices.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    // One requester's transaction, as latched into the bus registers.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr_rd;
    } bus_req_t;

    // Selects the transaction fields of the requester named by idx.
    function automatic bus_req_t pick_req(input logic idx,
                                          input bus_req_t r0,
                                          input bus_req_t r1);
        return (idx == REQ_DMA) ? r1 : r0;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester handshakes and the external memory bus around the arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req until their done pulse; the slave stalls via bus_ready.
//
// Modports:
//   master - the arbiter: consumes requests, drives grants/completions and the bus
//   slave  - the surroundings: requesters plus the memory/peripheral decoder
interface mem_bus_arbiter_if;

    // Requester 0 (CPU memory stage)
    logic        req0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        wr_rd0;
    logic        gnt0;
    logic        done0;

    // Requester 1 (program-load / DMA engine)
    logic        req1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        wr_rd1;
    logic        gnt1;
    logic        done1;

    // Completion status shared by both requesters
    logic        err;
    logic [31:0] rdata;

    // External memory bus
    logic [31:0] addr;
    logic        cs;
    logic        wr_rd;
    logic [31:0] data_bus_write;
    logic [31:0] data_bus_read;
    logic        bus_ready;

    modport master (
        input  req0, addr0, wdata0, wr_rd0,
        input  req1, addr1, wdata1, wr_rd1,
        output gnt0, done0, gnt1, done1,
        output err, rdata,
        output addr, cs, wr_rd, data_bus_write,
        input  data_bus_read, bus_ready
    );

    modport slave (
        output req0, addr0, wdata0, wr_rd0,
        output req1, addr1, wdata1, wr_rd1,
        input  gnt0, done0, gnt1, done1,
        input  err, rdata,
        input  addr, cs, wr_rd, data_bus_write,
        output data_bus_read, bus_ready
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester that was not served last wins.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to act on the pick.
//
// Ports:
//   req        [1:0] request vector, bit i = requester i
//   last_grant       index of the requester served most recently
//   gnt_idx          winning requester index (meaningful only when gnt_vld)
//   gnt_vld          at least one request is pending
module rr_arbiter2
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_idx,
    output logic       gnt_vld
);

    always_comb begin
        gnt_vld = |req;
        gnt_idx = REQ_CPU;
        if (req[REQ_CPU] && req[REQ_DMA]) begin
            gnt_idx = (last_grant == REQ_CPU) ? REQ_DMA : REQ_CPU;
        end else if (req[REQ_DMA]) begin
            gnt_idx = REQ_DMA;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between the CPU memory stage and the DMA engine.
// Latency: req in cycle N -> cs from N+1 -> done in N+2+WAIT_STATES (bus_ready high).
// Backpressure: requesters wait on gnt/done; the slave stretches BUSY via bus_ready, bounded by TIMEOUT.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset; drops cs/gnt immediately, no done is issued
//   bus  mem_bus_arbiter_if.master: req/addr/wdata/wr_rd per requester in,
//        gnt/done per requester out, err/rdata out, external bus out, data_bus_read/bus_ready in
//
// Parameters:
//   WAIT_STATES  bus cycles cs is held before bus_ready is looked at (0..15)
//   TIMEOUT      BUSY cycles after which the transaction ends with err (WAIT_STATES < TIMEOUT < 256)
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.master  bus
);

    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic        last_grant;
    logic        cur_idx;
    logic        err_flag;
    logic [3:0]  ws_cnt;
    logic [7:0]  to_cnt;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        wr_rd_q;
    logic        cs_q;
    logic [31:0] rdata_q;
    logic        gnt0_q;
    logic        gnt1_q;

    logic        arb_idx;
    logic        arb_vld;
    bus_req_t    req0_fields;
    bus_req_t    req1_fields;
    bus_req_t    winner;

    // ------------------------------------------------------------------
    // Arbitration (only acted on in IDLE; requester inputs are don't-care
    // at every other time)
    // ------------------------------------------------------------------
    rr_arbiter2 u_rr (
        .req        ({bus.req1, bus.req0}),
        .last_grant (last_grant),
        .gnt_idx    (arb_idx),
        .gnt_vld    (arb_vld)
    );

    always_comb begin
        req0_fields = '{addr: bus.addr0, wdata: bus.wdata0, wr_rd: bus.wr_rd0};
        req1_fields = '{addr: bus.addr1, wdata: bus.wdata1, wr_rd: bus.wr_rd1};
        winner      = pick_req(arb_idx, req0_fields, req1_fields);
    end

    // ------------------------------------------------------------------
    // Transaction FSM, counters and bus registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= REQ_DMA;      // so the CPU wins the first tie
            cur_idx    <= REQ_CPU;
            err_flag   <= 1'b0;
            ws_cnt     <= 4'd0;
            to_cnt     <= 8'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wr_rd_q    <= 1'b0;
            cs_q       <= 1'b0;
            rdata_q    <= 32'd0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        addr_q   <= winner.addr;
                        wdata_q  <= winner.wdata;
                        wr_rd_q  <= winner.wr_rd;
                        cs_q     <= 1'b1;
                        gnt0_q   <= (arb_idx == REQ_CPU);
                        gnt1_q   <= (arb_idx == REQ_DMA);
                        cur_idx  <= arb_idx;
                        ws_cnt   <= WS_INIT;
                        to_cnt   <= 8'd0;
                        err_flag <= 1'b0;
                        state    <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    to_cnt <= to_cnt + 8'd1;
                    if (ws_cnt != 4'd0) begin
                        ws_cnt <= ws_cnt - 4'd1;
                    end
                    // A ready slave takes priority over an expiring timeout in
                    // the same cycle. cs is dropped on the way out so it is
                    // already low during RESP.
                    if ((ws_cnt == 4'd0) && bus.bus_ready) begin
                        if (!wr_rd_q) begin
                            rdata_q <= bus.data_bus_read;
                        end
                        cs_q  <= 1'b0;
                        state <= ST_RESP;
                    end else if (to_cnt == TO_LAST) begin
                        err_flag <= 1'b1;
                        rdata_q  <= 32'd0;
                        cs_q     <= 1'b0;
                        state    <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    gnt0_q     <= 1'b0;
                    gnt1_q     <= 1'b0;
                    last_grant <= cur_idx;
                    state      <= ST_IDLE;
                end

                default: begin
                    cs_q   <= 1'b0;
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: done/err are decoded from RESP so they last exactly one
    // cycle and vanish with the state register on reset.
    // ------------------------------------------------------------------
    always_comb begin
        bus.gnt0           = gnt0_q;
        bus.gnt1           = gnt1_q;
        bus.done0          = (state == ST_RESP) && (cur_idx == REQ_CPU);
        bus.done1          = (state == ST_RESP) && (cur_idx == REQ_DMA);
        bus.err            = (state == ST_RESP) && err_flag;
        bus.rdata          = rdata_q;
        bus.addr           = addr_q;
        bus.cs             = cs_q;
        bus.wr_rd          = wr_rd_q;
        bus.data_bus_write = wdata_q;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected completions,
// a negedge monitor checks bus contents during cs and each done pulse.
module tb_mem_bus_arbiter;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          cs_len;   // 0 = do not check
        int          gap;      // cycles since previous done, 0 = do not check
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(
        .WAIT_STATES (2),
        .TIMEOUT     (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   cs_cycles = 0;
    int   last_done_cyc = -1000;
    int   lat;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push(input int port, input logic [31:0] a, input logic w,
                        input logic [31:0] wd, input logic [31:0] rd, input logic e,
                        input int csl, input int gap);
        exp_t x;
        x.port = port; x.addr = a; x.wr = w; x.wdata = wd;
        x.rdata = rd; x.err = e; x.cs_len = csl; x.gap = gap;
        exp_q.push_back(x);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits for n done pulses; returns the number of cycles taken.
    task automatic wait_done(input int n, input int bound, output int cycles);
        int seen;
        seen   = 0;
        cycles = 0;
        while (seen < n && cycles < bound) begin
            tick();
            cycles++;
            if (bus.done0 || bus.done1) seen++;
        end
        if (seen < n) begin
            total++;
            bad++;
            $display("FAIL wait_done_timeout: got %0d dones expected %0d", seen, n);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            cs_cycles = 0;
        end else begin
            check("gnt_mutex", 32'(bus.gnt0 & bus.gnt1), 32'd0);
            if (bus.cs) begin
                cs_cycles++;
                if (exp_q.size() == 0) begin
                    check("cs_unexpected", 32'(bus.cs), 32'd0);
                end else begin
                    check("bus_addr",  bus.addr,               exp_q[0].addr);
                    check("bus_wr_rd", 32'(bus.wr_rd),         32'(exp_q[0].wr));
                    check("bus_wdata", bus.data_bus_write,     exp_q[0].wdata);
                    check("bus_gnt0",  32'(bus.gnt0),          32'(exp_q[0].port == 0));
                    check("bus_gnt1",  32'(bus.gnt1),          32'(exp_q[0].port == 1));
                end
            end
            if (bus.done0 || bus.done1) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'({bus.done1, bus.done0}), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_port", 32'({bus.done1, bus.done0}),
                          (mon_e.port == 0) ? 32'd1 : 32'd2);
                    check("done_gnt", 32'({bus.gnt1, bus.gnt0}),
                          (mon_e.port == 0) ? 32'd1 : 32'd2);
                    check("err", 32'(bus.err), 32'(mon_e.err));
                    check("rdata", bus.rdata, mon_e.rdata);
                    check("cs_in_done", 32'(bus.cs), 32'd0);
                    if (mon_e.cs_len > 0) check("cs_len", cs_cycles, mon_e.cs_len);
                    if (mon_e.gap > 0)    check("done_gap", cyc - last_done_cyc, mon_e.gap);
                end
                cs_cycles     = 0;
                last_done_cyc = cyc;
            end else if (bus.err) begin
                check("err_without_done", 32'(bus.err), 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bus.req0 = 0; bus.addr0 = 0; bus.wdata0 = 0; bus.wr_rd0 = 0;
        bus.req1 = 0; bus.addr1 = 0; bus.wdata1 = 0; bus.wr_rd1 = 0;
        bus.data_bus_read = 0; bus.bus_ready = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs",    32'(bus.cs),    32'd0);
        check("rst_gnt",   32'({bus.gnt1, bus.gnt0}),   32'd0);
        check("rst_done",  32'({bus.done1, bus.done0}), 32'd0);
        check("rst_err",   32'(bus.err),   32'd0);
        check("rst_rdata", bus.rdata,      32'd0);
        check("rst_addr",  bus.addr,       32'd0);
        check("rst_wr_rd", 32'(bus.wr_rd), 32'd0);
        check("rst_wdata", bus.data_bus_write, 32'd0);
        rst = 1;
        tick();

        // Single read: cs cycles 1-3, done in cycle 4
        bus.addr0 = 32'h10; bus.wr_rd0 = 0; bus.wdata0 = 32'h0;
        bus.data_bus_read = 32'hDEADBEEF; bus.bus_ready = 1;
        push(0, 32'h10, 0, 32'h0, 32'hDEADBEEF, 0, 3, 0);
        bus.req0 = 1;
        wait_done(1, 20, lat);
        check("read_latency", lat, 4);
        bus.req0 = 0;
        tick();

        // Timeout: 64 BUSY cycles, done/err in the 65th cycle after the grant edge
        bus.addr0 = 32'h20; bus.data_bus_read = 32'hCAFEF00D; bus.bus_ready = 0;
        push(0, 32'h20, 0, 32'h0, 32'h0, 1, 64, 0);
        bus.req0 = 1;
        wait_done(1, 100, lat);
        check("timeout_latency", lat, 65);
        bus.req0 = 0; bus.bus_ready = 1;
        tick();

        // Normal read after the timeout
        bus.addr0 = 32'h24; bus.data_bus_read = 32'h0BADF00D;
        push(0, 32'h24, 0, 32'h0, 32'h0BADF00D, 0, 3, 0);
        bus.req0 = 1;
        wait_done(1, 20, lat);
        check("post_timeout_latency", lat, 4);
        bus.req0 = 0;
        tick();

        // Write with slow slave: ready low for 5 cycles past the wait states
        bus.addr1 = 32'h40; bus.wdata1 = 32'hA5A5A5A5; bus.wr_rd1 = 1;
        bus.bus_ready = 0; bus.data_bus_read = 32'hFFFF0000;
        push(1, 32'h40, 1, 32'hA5A5A5A5, 32'h0BADF00D, 0, 8, 0);
        bus.req1 = 1;
        repeat (8) tick();
        bus.bus_ready = 1;
        wait_done(1, 10, lat);
        check("done_after_ready", lat, 1);
        bus.req1 = 0;
        tick();

        // Tie and fairness: last served was requester 1, so order 0,1,0,1
        bus.addr0 = 32'h100; bus.wdata0 = 32'h11111111; bus.wr_rd0 = 0;
        bus.addr1 = 32'h200; bus.wdata1 = 32'h22222222; bus.wr_rd1 = 1;
        bus.data_bus_read = 32'h76543210;
        push(0, 32'h100, 0, 32'h11111111, 32'h76543210, 0, 3, 0);
        push(1, 32'h200, 1, 32'h22222222, 32'h76543210, 0, 3, 5);
        push(0, 32'h100, 0, 32'h11111111, 32'h76543210, 0, 3, 5);
        push(1, 32'h200, 1, 32'h22222222, 32'h76543210, 0, 3, 5);
        bus.req0 = 1; bus.req1 = 1;
        wait_done(4, 40, lat);
        check("tie_total_cycles", lat, 19);
        bus.req0 = 0; bus.req1 = 0;
        tick();

        // Request withdrawn in the second BUSY cycle
        bus.addr0 = 32'h300; bus.data_bus_read = 32'h13579BDF;
        push(0, 32'h300, 0, 32'h11111111, 32'h13579BDF, 0, 3, 0);
        bus.req0 = 1;
        tick();
        tick();
        bus.req0 = 0;
        wait_done(1, 10, lat);
        check("withdrawn_done", lat, 2);
        tick();

        // Reset mid-transaction
        bus.addr0 = 32'h400; bus.bus_ready = 0;
        push(0, 32'h400, 0, 32'h11111111, 32'h0, 0, 0, 0);
        bus.req0 = 1;
        repeat (3) tick();
        check("cs_before_reset", 32'(bus.cs), 32'd1);
        rst = 0;
        #1;
        check("reset_cs",   32'(bus.cs),   32'd0);
        check("reset_gnt",  32'({bus.gnt1, bus.gnt0}),   32'd0);
        check("reset_done", 32'({bus.done1, bus.done0}), 32'd0);
        exp_q.delete();
        bus.req0 = 0;
        tick();
        tick();
        check("reset_hold_done", 32'({bus.done1, bus.done0}), 32'd0);
        bus.addr0 = 32'h500; bus.wdata0 = 32'h55; bus.wr_rd0 = 0;
        bus.addr1 = 32'h600; bus.wdata1 = 32'h66; bus.wr_rd1 = 0;
        bus.data_bus_read = 32'h89ABCDEF; bus.bus_ready = 1;
        push(0, 32'h500, 0, 32'h55, 32'h89ABCDEF, 0, 3, 0);
        push(1, 32'h600, 0, 32'h66, 32'h89ABCDEF, 0, 3, 5);
        bus.req0 = 1; bus.req1 = 1;
        rst = 1;
        wait_done(2, 30, lat);
        bus.req0 = 0; bus.req1 = 0;
        tick();
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
